// File: rtl/merge_n.sv
// merge_n: select-driven N-to-1 token merge with a small output FIFO.
// A select token names which input supplies the next data token. That token
// is routed into the FIFO, and the FSM then returns to wait for the next select.
module merge_n #(
  parameter int WIDTH  = 9,
  parameter int NUM_IN = 2,
  parameter int SEL_W  = $clog2(NUM_IN),
  parameter int DEPTH  = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    sel_valid,
  output logic                    sel_ready,
  input  logic [SEL_W-1:0]        sel_data,
  input  logic [NUM_IN-1:0]       in_valid,
  output logic [NUM_IN-1:0]       in_ready,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic                    err_sel,
  output logic [15:0]             tok_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [SEL_W:0] NUM_IN_L = (SEL_W+1)'(NUM_IN);

  typedef enum logic {IDLE, ROUTE} state_t;

  state_t                       state_q, state_d;
  logic [SEL_W-1:0]             sel_q, sel_d;
  logic                         err_q, err_d;
  logic [15:0]                  tok_cnt_q, tok_cnt_d;
  logic [AW:0]                  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0]             mem_q [DEPTH];
  logic [WIDTH-1:0]             mem_d [DEPTH];

  logic [NUM_IN-1:0][WIDTH-1:0] in_vec;
  logic                         fifo_full, fifo_empty;
  logic                         sel_ok, push, pop, route_open;

  assign in_vec = in_data;

  // Extra pointer bit separates full (MSBs differ) from empty (pointers equal).
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  assign sel_ok = ({1'b0, sel_data} < NUM_IN_L);

  // Readiness depends only on state and FIFO fullness, never on out_ready.
  assign route_open = rst_n && (state_q == ROUTE) && !fifo_full;
  assign sel_ready  = rst_n && (state_q == IDLE);

  // Only the latched input's ready is asserted; the others stay low.
  for (genvar i = 0; i < NUM_IN; i++) begin : g_rdy
    assign in_ready[i] = route_open && (sel_q == SEL_W'(i));
  end

  assign out_valid = !fifo_empty;
  assign out_data  = fifo_empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
  assign pop       = out_valid && out_ready;
  assign err_sel   = err_q;
  assign tok_cnt   = tok_cnt_q;

  // FSM next-state plus the select latch, error flag and token counter.
  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    err_d     = err_q;
    tok_cnt_d = tok_cnt_q;
    push      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (sel_valid) begin
          if (sel_ok) begin
            sel_d   = sel_data;
            state_d = ROUTE;
          end else begin
            err_d = 1'b1;  // consume the bad token, stay in IDLE
          end
        end
      end
      ROUTE: begin
        if (route_open && in_valid[sel_q]) begin
          push      = 1'b1;
          tok_cnt_d = tok_cnt_q + 16'd1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FIFO pointer advance and storage write.
  always_comb begin
    wr_ptr_d = wr_ptr_q + (AW+1)'(push);
    rd_ptr_d = rd_ptr_q + (AW+1)'(pop);
    mem_d    = mem_q;
    if (push) mem_d[wr_ptr_q[AW-1:0]] = in_vec[sel_q];
  end

  // Control state with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      sel_q     <= '0;
      err_q     <= 1'b0;
      tok_cnt_q <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      err_q     <= err_d;
      tok_cnt_q <= tok_cnt_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
    end
  end

  // FIFO storage; contents are don't-care while empty since out_data is gated.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule
